lut_cfg_sequencer: RTL

Configuration and run controller for an array of `NUM_LUTS` `lut` instances. It accepts a serial truth-table bitstream over a valid/ready handshake and buffers one LUT's worth of bits. It replays those bits to each LUT in turn with the exact cfg/data timing the LUT requires, then hands the shared run strobe to the user. It sits between the chip-level config port and the LUT fabric and is the only driver of every LUT's `cfg`, `cfg_truth_table_data` and `run` inputs.

---
 rtl/lut_cfg_sequencer_pkg.sv | 23 ++
 rtl/lut_cfg_sequencer_buffer.sv | 27 ++
 rtl/lut_cfg_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lut_cfg_sequencer_pkg.sv
// Shared types for the LUT configuration sequencer and the LUT fabric it drives.
package lut_cfg_sequencer_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_FILL  = 3'd1,
      SEQ_PRIME = 3'd2,
      SEQ_LOAD  = 3'd3,
      SEQ_READY = 3'd4
   } lut_seq_state_t;

   typedef enum logic [1:0] {
      LUT_INIT   = 2'd0,
      LUT_CONFIG = 2'd1,
      LUT_IDLE   = 2'd2,
      LUT_RUN    = 2'd3
   } lut_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lut_cfg_sequencer_buffer.sv
// One LUT's worth of truth-table bits: written by index during FILL, read by index during LOAD.
module lut_cfg_sequencer_buffer #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 1 << WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_idx,
   input  logic             wr_data,
   input  logic [WIDTH-1:0] rd_idx,
   output logic             rd_data
);

   logic [DEPTH-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
      end else if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/lut_cfg_sequencer.sv
// Buffers one LUT's truth table from the bitstream port, then replays it to each LUT in turn
// with cfg high for DEPTH cycles and data lagging by one cycle; afterwards owns the run strobe.
module lut_cfg_sequencer
   import lut_cfg_sequencer_pkg::*;
#(
   parameter int WIDTH    = 2,
   parameter int DEPTH    = 1 << WIDTH,
   parameter int NUM_LUTS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                bs_valid,
   input  logic                bs_data,
   output logic                bs_ready,
   input  logic                run_req,
   output logic [NUM_LUTS-1:0] lut_cfg,
   output logic                lut_cfg_data,
   output logic                lut_run,
   output logic                busy,
   output logic                configured,
   output logic                cfg_done
);

   localparam int IDX_W = idx_width(NUM_LUTS);
   localparam int CNT_W = WIDTH + 1;

   lut_seq_state_t   state_q;
   logic [IDX_W-1:0] lut_idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             configured_q;
   logic             done_q;

   logic             wr_en_s;
   logic [WIDTH-1:0] rd_idx_s;
   logic             rd_data_s;
   logic             load_cfg_s;

   assign wr_en_s  = (state_q == SEQ_FILL) && bs_valid;
   // At cnt=DEPTH the low bits are zero, so the wrapped decrement still addresses entry DEPTH-1.
   assign rd_idx_s = cnt_q[WIDTH-1:0] - WIDTH'(1);

   lut_cfg_sequencer_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_idx  (cnt_q[WIDTH-1:0]),
      .wr_data (bs_data),
      .rd_idx  (rd_idx_s),
      .rd_data (rd_data_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SEQ_IDLE;
         lut_idx_q    <= '0;
         cnt_q        <= '0;
         configured_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SEQ_IDLE: begin
               if (cfg_start) begin
                  state_q      <= SEQ_FILL;
                  lut_idx_q    <= '0;
                  cnt_q        <= '0;
                  configured_q <= 1'b0;
               end
            end
            SEQ_FILL: begin
               if (bs_valid) begin
                  if (cnt_q == CNT_W'(DEPTH - 1)) begin
                     state_q <= SEQ_PRIME;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            SEQ_PRIME: begin
               state_q <= SEQ_LOAD;
               cnt_q   <= '0;
            end
            SEQ_LOAD: begin
               if (cnt_q == CNT_W'(DEPTH)) begin
                  cnt_q <= '0;
                  if (lut_idx_q == IDX_W'(NUM_LUTS - 1)) begin
                     state_q      <= SEQ_READY;
                     configured_q <= 1'b1;
                     done_q       <= 1'b1;
                  end else begin
                     state_q   <= SEQ_FILL;
                     lut_idx_q <= lut_idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            SEQ_READY: begin
               if (cfg_start) begin
                  state_q      <= SEQ_FILL;
                  lut_idx_q    <= '0;
                  cnt_q        <= '0;
                  configured_q <= 1'b0;
               end
            end
            default: begin
               state_q <= SEQ_IDLE;
            end
         endcase
      end
   end

   // PRIME pulses run so already-configured LUTs leave IDLE and can re-enter CONFIG next cycle.
   always_comb begin
      load_cfg_s = (state_q == SEQ_LOAD) && (cnt_q < CNT_W'(DEPTH));
      lut_cfg    = '0;
      for (int k = 0; k < NUM_LUTS; k++) begin
         lut_cfg[k] = load_cfg_s && (lut_idx_q == IDX_W'(k));
      end
      if ((state_q == SEQ_LOAD) && (cnt_q != '0)) begin
         lut_cfg_data = rd_data_s;
      end else begin
         lut_cfg_data = 1'b0;
      end
      lut_run  = (state_q == SEQ_PRIME) ||
                 ((state_q == SEQ_READY) && run_req && !cfg_start);
      bs_ready = (state_q == SEQ_FILL);
      busy     = (state_q == SEQ_FILL) || (state_q == SEQ_PRIME) || (state_q == SEQ_LOAD);
   end

   assign configured = configured_q;
   assign cfg_done   = done_q;

endmodule
